shift_and_subtract_binary_divider: RTL



---
 rtl/shift_and_subtract_binary_divider.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shift_and_subtract_binary_divider.sv
// rtl/shift_and_subtract_binary_divider.sv - restoring divider, one quotient bit per clock
// Optional build macro: SIGNED_DIV_EN (two's-complement operands, truncating division)
module shift_and_subtract_binary_divider #(
  parameter int m = 8,
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [m-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [m-1:0] Q,
  output logic [n-1:0] R,
  output logic         div_by_zero
);

  localparam int CW = $clog2(m + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [n:0]    r_rem;
  logic [m-1:0]  r_dvd;
  logic [m-1:0]  r_quo;
  logic [n-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [m-1:0]  r_q;
  logic [n-1:0]  r_r;
  logic          r_dbz;

  logic [m-1:0]  w_a_mag;
  logic [n-1:0]  w_b_mag;
  logic [n:0]    w_rem_sh;
  logic          w_ge;
  logic [n:0]    w_rem_nx;
  logic [m-1:0]  w_quo_nx;
  logic [m-1:0]  w_q_fin;
  logic [n-1:0]  w_r_fin;
  logic          w_b_zero;
  logic          w_last;

`ifdef SIGNED_DIV_EN
  logic r_sa;
  logic r_sb;
  // The unsigned core works on magnitudes; the most-negative value maps to itself, which still reads correctly as unsigned.
  assign w_a_mag = A[m-1] ? (~A + 1'b1) : A;
  assign w_b_mag = B[n-1] ? (~B + 1'b1) : B;
  assign w_q_fin = (r_sa ^ r_sb) ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_r_fin = r_sa ? (~w_rem_nx[n-1:0] + 1'b1) : w_rem_nx[n-1:0];
`else
  assign w_a_mag = A;
  assign w_b_mag = B;
  assign w_q_fin = w_quo_nx;
  assign w_r_fin = w_rem_nx[n-1:0];
`endif

  assign w_b_zero = (B == '0);
  assign w_last   = (r_cnt == CW'(1));
  assign w_rem_sh = {r_rem[n-1:0], r_dvd[m-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
  assign w_quo_nx = {r_quo[m-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = w_b_zero ? DONE : CALC;
      CALC:    if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_quo <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_rem <= '0;
          r_dvd <= w_a_mag;
          r_quo <= '0;
          r_b   <= w_b_mag;
          r_cnt <= CW'(m);
`ifdef SIGNED_DIV_EN
          r_sa  <= A[m-1];
          r_sb  <= B[n-1];
`endif
          if (w_b_zero) begin
            r_q   <= '1;
            r_r   <= '0;
            r_dbz <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[m-2:0], 1'b0};
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          // Results are published on the same edge that enters DONE.
          if (w_last) begin
            r_q   <= w_q_fin;
            r_r   <= w_r_fin;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == DONE);
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;

endmodule
